// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types and constants for the instruction-fetch controller
package ifetch_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int          ENTRY_W = $bits(fetch_entry_t);
    localparam logic [31:0] PC_STEP = 32'd1;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous prefetch FIFO of {pc, instr} entries with flush
module fetch_queue
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [ENTRY_W-1:0]     wdata,
    output logic [ENTRY_W-1:0]     rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= fetch_entry_t'(wdata);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// rtl/ifetch_ctrl.sv - PC, fetch FSM and redirect logic feeding decode through a prefetch queue
// Optional IFETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt counters.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] RESET_PC   = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t       state;
    logic [31:0]        pc;
    logic               fetch;
    logic               deq;
    logic               q_full;
    logic               q_empty;
    logic [CW-1:0]      q_count_unused;
    logic [ENTRY_W-1:0] q_wdata;
    logic [ENTRY_W-1:0] q_rdata;
    fetch_entry_t       head;

    assign imem_addr = pc;
    assign out_valid = !q_empty;
    assign deq       = out_valid && out_ready;
    // Redirect wins over fetch: the word at the old PC must never be enqueued.
    assign fetch     = (state == RUN) && !redirect_valid && (!q_full || deq);
    assign q_wdata   = {pc, imem_instr};
    assign head      = fetch_entry_t'(q_rdata);
    assign out_instr = out_valid ? head.instr : 32'd0;
    assign out_pc    = out_valid ? head.pc    : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            case (state)
                IDLE:    if (fetch_en)  state <= RUN;
                RUN:     if (!fetch_en) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (redirect_valid) begin
                pc <= redirect_pc;
            end else if (fetch) begin
                pc <= pc + PC_STEP;
            end
        end
    end

    fetch_queue #(
        .DEPTH(FIFO_DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (fetch),
        .pop   (deq),
        .flush (redirect_valid),
        .wdata (q_wdata),
        .rdata (q_rdata),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count_unused)
    );

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            if (fetch)                   perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (out_valid && !out_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb/tb_ifetch_ctrl.sv - self-checking bench for ifetch_ctrl with a queue-based reference model
module tb_ifetch_ctrl;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'd0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        out_ready = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Memory of depth 512: word i holds i+0x100, beyond that reads as 0.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a < 32'd512) ? a + 32'h100 : 32'd0;
    endfunction

    assign imem_instr = mem_word(imem_addr);

    ifetch_ctrl #(
        .FIFO_DEPTH(DEPTH),
        .RESET_PC  (RPC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_en      (fetch_en),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    // Reference model: running flag, PC and a queue of delivered-to-be words.
    logic [31:0] m_pc;
    bit          m_run;
    logic [31:0] m_qpc [$];
    logic [31:0] m_qin [$];

    task automatic tick();
        int sz;
        bit deq;
        @(posedge clk);
        sz  = m_qpc.size();
        deq = (sz > 0) && out_ready;
        if (rst) begin
            m_pc  = RPC;
            m_run = 1'b0;
            m_qpc.delete();
            m_qin.delete();
        end else begin
            if (deq) begin
                void'(m_qpc.pop_front());
                void'(m_qin.pop_front());
            end
            if (redirect_valid) begin
                m_qpc.delete();
                m_qin.delete();
                m_pc = redirect_pc;
            end else if (m_run && (sz < DEPTH || deq)) begin
                m_qpc.push_back(m_pc);
                m_qin.push_back(mem_word(m_pc));
                m_pc = m_pc + 32'd1;
            end
            m_run = fetch_en;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fetch_en = 1'b0;
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (out_valid !== 1'b0 || out_pc !== 32'd0 || out_instr !== 32'd0 || imem_addr !== RPC) begin
            n_fail++;
            $display("FAIL reset: valid=%0b pc=%h instr=%h addr=%h, want 0/0/0/%h",
                     out_valid, out_pc, out_instr, imem_addr, RPC);
        end
`ifdef IFETCH_PERF_EN
        n_tests++;
        if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_perf: fetch=%0d stall=%0d, want 0/0", perf_fetch_cnt, perf_stall_cnt);
        end
`endif
    endtask

    task automatic test_stream();
        do_reset();
        fetch_en = 1'b1;
        out_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_tests++;
            if (k == 1) begin
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stream_first: cycle %0d valid=%0b want 0", k, out_valid);
                end
            end else if (out_valid !== 1'b1 || out_pc !== 32'(k - 2) || out_instr !== 32'(k - 2) + 32'h100) begin
                n_fail++;
                $display("FAIL stream: cycle %0d valid=%0b pc=%h instr=%h, want 1/%h/%h",
                         k, out_valid, out_pc, out_instr, 32'(k - 2), 32'(k - 2) + 32'h100);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        fetch_en = 1'b1;
        out_ready = 1'b0;
        tick();
        for (int k = 2; k <= 6; k++) begin
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || out_pc !== 32'd0 || out_instr !== 32'h100 ||
                (k >= 3 && imem_addr !== 32'd2)) begin
                n_fail++;
                $display("FAIL backpressure_hold: cycle %0d valid=%0b pc=%h instr=%h addr=%h, want 1/0/100/2",
                         k, out_valid, out_pc, out_instr, imem_addr);
            end
        end
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || out_pc !== 32'(k)) begin
                n_fail++;
                $display("FAIL backpressure_release: step %0d valid=%0b pc=%h, want 1/%h",
                         k, out_valid, out_pc, 32'(k));
            end
        end
    endtask

    task automatic test_redirect_full();
        do_reset();
        fetch_en = 1'b1;
        out_ready = 1'b0;
        repeat (4) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h20;
        tick();
        redirect_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || imem_addr !== 32'h20) begin
            n_fail++;
            $display("FAIL redirect_full_n1: valid=%0b addr=%h, want 0/20", out_valid, imem_addr);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'h20 || out_instr !== 32'h120) begin
            n_fail++;
            $display("FAIL redirect_full_n2: valid=%0b pc=%h instr=%h, want 1/20/120", out_valid, out_pc, out_instr);
        end
        out_ready = 1'b1;
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'h21) begin
            n_fail++;
            $display("FAIL redirect_full_n3: valid=%0b pc=%h, want 1/21", out_valid, out_pc);
        end
    endtask

    task automatic test_redirect_dequeue();
        do_reset();
        fetch_en = 1'b1;
        out_ready = 1'b1;
        repeat (5) tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'd3) begin
            n_fail++;
            $display("FAIL redir_deq_pre: valid=%0b pc=%h, want 1/3", out_valid, out_pc);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_deq_n1: valid=%0b pc=%h, want valid 0", out_valid, out_pc);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || out_pc !== 32'h40 + 32'(k)) begin
                n_fail++;
                $display("FAIL redir_deq_n%0d: valid=%0b pc=%h, want 1/%h", k + 2, out_valid, out_pc, 32'h40 + 32'(k));
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        fetch_en = 1'b1;
        out_ready = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || imem_addr !== RPC || out_pc !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid: valid=%0b addr=%h pc=%h, want 0/%h/0", out_valid, imem_addr, out_pc, RPC);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_idle: valid=%0b want 0", out_valid);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_pc !== RPC) begin
            n_fail++;
            $display("FAIL reset_mid_restart: valid=%0b pc=%h, want 1/%h", out_valid, out_pc, RPC);
        end
    endtask

    task automatic test_random();
        logic        ev;
        logic [31:0] epc;
        logic [31:0] ein;
        int          nfail_here = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst            = ($urandom_range(0, 199) == 0);
            fetch_en       = ($urandom_range(0, 9) != 0);
            out_ready      = $urandom_range(0, 1) == 1;
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 600));
            tick();
            ev  = (m_qpc.size() > 0);
            epc = ev ? m_qpc[0] : 32'd0;
            ein = ev ? m_qin[0] : 32'd0;
            n_tests++;
            if (out_valid !== ev || out_pc !== epc || out_instr !== ein || imem_addr !== m_pc) begin
                n_fail++;
                if (nfail_here < 10)
                    $display("FAIL random: cycle %0d valid=%0b pc=%h instr=%h addr=%h, want %0b/%h/%h/%h",
                             i, out_valid, out_pc, out_instr, imem_addr, ev, epc, ein, m_pc);
                nfail_here++;
            end
        end
        rst = 1'b0;
        redirect_valid = 1'b0;
    endtask

`ifdef IFETCH_PERF_EN
    task automatic test_perf();
        do_reset();
        fetch_en = 1'b1;
        out_ready = 1'b1;
        tick();
        repeat (9) tick();
        fetch_en = 1'b0;
        tick();
        out_ready = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (perf_fetch_cnt !== 32'd10 || perf_stall_cnt !== 32'd3) begin
            n_fail++;
            $display("FAIL perf: fetch=%0d stall=%0d, want 10/3", perf_fetch_cnt, perf_stall_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_redirect_dequeue();
        test_reset_mid();
        test_random();
`ifdef IFETCH_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch controller for the single-issue MIPS-32 core. Owns the program counter and drives the combinational, word-addressed instruction memory. Buffers fetched words in a small prefetch queue and hands them to decode over a valid/ready handshake. Decode/execute can redirect it on a branch or jump, which flushes in-flight fetches.

## Interface
- `FIFO_DEPTH`, 2: prefetch queue entries; power of two, ≥2.
- `RESET_PC`, 32'd0: word index loaded into PC at reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `fetch_en` in 1: level; high starts and keeps fetching, low pauses new fetches (queue still drains).
- `imem_addr` out 32: word index to instruction memory; equals PC.
- `imem_instr` in 32: instruction word; valid combinationally in the same cycle as `imem_addr`. Memory returns 0 past its depth.
- `redirect_valid` in 1: single-cycle redirect request.
- `redirect_pc` in 32: target word index, sampled when `redirect_valid`=1.
- `out_valid` out 1: queue head holds a valid instruction.
- `out_ready` in 1: decode accepts the head this cycle.
- `out_instr` out 32: head instruction; 0 when `out_valid`=0.
- `out_pc` out 32: word index of head instruction; 0 when `out_valid`=0.

## Operation
- FSM states: IDLE, RUN.
  - IDLE → RUN when `fetch_en`=1.
  - RUN → IDLE when `fetch_en`=0.
  - `rst` → IDLE from any state.
- Fetch enable: in RUN, a fetch occurs when the queue is not full, or when it is full and a dequeue happens the same cycle.
- Fetch action: enqueue {PC, `imem_instr`}, then PC ← PC+1. PC wraps modulo 2^32.
- Dequeue: when `out_valid` && `out_ready`. Head advances and the count decrements.
- Simultaneous fetch and dequeue: count unchanged. This is legal when empty only if the fetch fills the slot, and the new entry is not visible until the next cycle. There is no bypass.
- Redirect (any state):
  - Queue flushed.
  - PC ← `redirect_pc`.
  - No enqueue that cycle.
  - A concurrent dequeue still counts as accepted by decode.
  - Redirect has priority over fetch.
- Redirect while in IDLE: PC updates, and fetching resumes from the new PC when `fetch_en` rises.
- Reset values:
  - PC=`RESET_PC`, queue empty, state IDLE.
  - `out_valid`=0, `out_instr`=0, `out_pc`=0.
  - `imem_addr`=`RESET_PC`.
- Reset mid-operation discards all queued entries. No partial handshake survives.
- An all-zero instruction is a NOP and is delivered like any other word.

## Timing
- Fetch-to-output latency: 1 cycle. A word fetched in cycle N is visible at the head in cycle N+1.
- Redirect-to-valid latency: 2 cycles. Redirect in cycle N, fetch of target in N+1, `out_valid` in N+2.
- Throughput: 1 instruction/cycle sustained while `out_ready`=1.
- `out_instr`/`out_pc` stay stable while `out_valid`=1 and `out_ready`=0.
- After `fetch_en`=1 with an empty queue, the first `out_valid` is 2 cycles after the rise (IDLE→RUN, fetch, visible).

## Configuration
- `IFETCH_PERF_EN` defined adds two outputs:
  - `perf_fetch_cnt` out 32: counts completed fetches.
  - `perf_stall_cnt` out 32: counts cycles with `out_valid`=1 and `out_ready`=0.
  - Both reset to 0 on `rst` and wrap modulo 2^32.
- Not defined: these ports and their counters do not exist. Core behaviour is identical either way.

## Structure
- Package `ifetch_pkg`:
  - `fetch_state_t` enum (IDLE, RUN).
  - `fetch_entry_t` struct {pc[31:0], instr[31:0]}.
  - `PC_STEP`=1 constant.
- Sub-module `fetch_queue`: synchronous FIFO of `fetch_entry_t`, depth `FIFO_DEPTH`, with push/pop/flush, full/empty/count.
- The PC register, FSM and redirect logic stay in `ifetch_ctrl`.

## Test plan
- Reset then `fetch_en`=1, `out_ready`=1, memory[i]=i+0x100 → `out_pc` 0,1,2,… on consecutive cycles from cycle 2, with `out_instr` = pc+0x100.
- `out_ready`=0 for 5 cycles with FIFO_DEPTH=2 → exactly 2 entries queued, `imem_addr` holds at 2, head stays pc=0 stable. Releasing `out_ready` → pcs 0,1,2 in order with no gap or duplicate.
- Redirect to 0x20 while queue full → next cycle `out_valid`=0, `imem_addr`=0x20. Two cycles after the redirect, `out_pc`=0x20; old entries are never delivered.
- Redirect and dequeue in the same cycle → dequeued word counted once, no further old words appear.
- `rst` asserted mid-stream with queue non-empty → next cycle `out_valid`=0, `imem_addr`=`RESET_PC`, state IDLE.
- With `IFETCH_PERF_EN`: 10 fetches plus 3 backpressure cycles → `perf_fetch_cnt`=10, `perf_stall_cnt`=3.
